draw_manager: RTL and testbench

DRAW_MANAGER -- requirements
Module: draw_manager

---
 rtl/frame_pkg.sv | 34 +++
 rtl/draw_write_stage.sv | 55 +++++
 rtl/draw_manager.sv | 202 ++++++++++++++++++++
 tb/tb_draw_manager.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared frame geometry, color depth, bus widths, FSM state encoding and
// pixel-address helpers for the draw manager and its write stage.
package frame_pkg;

  localparam int COLOR_DEPTH       = 9;
  localparam int DRAW_WIDTH        = 16;
  localparam int DRAW_HEIGHT       = 16;
  localparam int DRAW_WIDTH_ADDRW  = 5;
  localparam int DRAW_HEIGHT_ADDRW = 5;
  localparam int FB_DEPTH          = DRAW_WIDTH * DRAW_HEIGHT;
  localparam int FB_ADDRW          = $clog2(FB_DEPTH);
  localparam int SOURCE_SEL_ADDRW  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SELECT  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_FLUSH   = 3'd4,
    ST_DONE    = 3'd5
  } draw_state_e;

  // Coordinate buses are one bit wider than needed so off-screen pixels stay visible.
  function automatic logic pix_in_bounds(input logic [DRAW_WIDTH_ADDRW-1:0]  x,
                                         input logic [DRAW_HEIGHT_ADDRW-1:0] y);
    return (x < DRAW_WIDTH_ADDRW'(DRAW_WIDTH)) && (y < DRAW_HEIGHT_ADDRW'(DRAW_HEIGHT));
  endfunction

  function automatic logic [FB_ADDRW-1:0] pix_addr(input logic [DRAW_WIDTH_ADDRW-1:0]  x,
                                                   input logic [DRAW_HEIGHT_ADDRW-1:0] y);
    return FB_ADDRW'(int'(y) * DRAW_WIDTH + int'(x));
  endfunction

endpackage

// File: rtl/draw_write_stage.sv
// Single registered framebuffer write stage: clear fills take priority, sampled
// pixels are bounds/transparency filtered and converted to a linear address.
module draw_write_stage
  import frame_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear_en,
  input  logic [FB_ADDRW-1:0]          i_clear_addr,
  input  logic [COLOR_DEPTH-1:0]       i_clear_color,
  input  logic                         i_sample_en,
  input  logic [COLOR_DEPTH-1:0]       i_color,
  input  logic                         i_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  i_x,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] i_y,
  output logic                         o_fb_we,
  output logic [FB_ADDRW-1:0]          o_fb_addr,
  output logic [COLOR_DEPTH-1:0]       o_fb_data
);

  logic                   w_pix_ok;
  logic [FB_ADDRW-1:0]    w_pix_addr;
  logic                   r_fb_we;
  logic [FB_ADDRW-1:0]    r_fb_addr;
  logic [COLOR_DEPTH-1:0] r_fb_data;

  always_comb begin
    w_pix_ok   = i_sample_en && !i_transparent && pix_in_bounds(i_x, i_y);
    w_pix_addr = pix_addr(i_x, i_y);
  end

  // Address and data hold their last value while no write is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fb_we   <= 1'b0;
      r_fb_addr <= {FB_ADDRW{1'b0}};
      r_fb_data <= {COLOR_DEPTH{1'b0}};
    end else if (i_clear_en) begin
      r_fb_we   <= 1'b1;
      r_fb_addr <= i_clear_addr;
      r_fb_data <= i_clear_color;
    end else if (w_pix_ok) begin
      r_fb_we   <= 1'b1;
      r_fb_addr <= w_pix_addr;
      r_fb_data <= i_color;
    end else begin
      r_fb_we   <= 1'b0;
    end
  end

  assign o_fb_we   = r_fb_we;
  assign o_fb_addr = r_fb_addr;
  assign o_fb_data = r_fb_data;

endmodule

// File: rtl/draw_manager.sv
// Frame sequencer: clears the back buffer, then grants the pixel bus to each
// source in ascending ID and forwards its pixels to the framebuffer write port.
// Optional source-start watchdog enabled by defining DRAW_MANAGER_TIMEOUT_EN.
module draw_manager
  import frame_pkg::*;
#(
  parameter int                     NUM_SOURCES    = 4,
  parameter logic [COLOR_DEPTH-1:0] BG_COLOR       = {COLOR_DEPTH{1'b0}},
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  output logic                         frame_done,
  output logic                         busy,
  output logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel,
  output logic                         write_awaited,
  input  logic                         write_active,
  input  logic [COLOR_DEPTH-1:0]       write_color_data,
  input  logic                         write_transparent,
  input  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr,
  input  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr,
  output logic                         fb_we,
  output logic [FB_ADDRW-1:0]          fb_addr,
  output logic [COLOR_DEPTH-1:0]       fb_data,
  output logic                         fb_buffer_sel,
  output logic [NUM_SOURCES-1:0]       timeout_flags
);

  if (NUM_SOURCES < 1 || NUM_SOURCES > (1 << SOURCE_SEL_ADDRW)) begin : g_bad_num_sources
    $error("NUM_SOURCES does not fit write_source_sel");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  draw_state_e                 r_state;
  draw_state_e                 w_next_state;
  draw_state_e                 w_adv_state;
  logic [SOURCE_SEL_ADDRW-1:0] r_idx;
  logic [SOURCE_SEL_ADDRW-1:0] w_next_idx;
  logic [SOURCE_SEL_ADDRW-1:0] w_adv_idx;
  logic [FB_ADDRW-1:0]         r_clr_addr;
  logic                        w_clr_last;
  logic                        w_last_src;
  logic                        w_clear_en;
  logic                        w_sample;
  logic                        w_advance;
  logic                        w_to_expire;
  logic                        r_busy;
  logic                        r_awaited;
  logic                        r_frame_done;
  logic                        r_buf_sel;

  assign w_clr_last = (r_clr_addr == FB_ADDRW'(FB_DEPTH - 1));
  assign w_last_src = (r_idx == SOURCE_SEL_ADDRW'(NUM_SOURCES - 1));
  assign w_clear_en = (r_state == ST_CLEAR);

  // Where the sequencer goes once the current source is finished or skipped.
  always_comb begin
    if (w_last_src) begin
      w_adv_state = ST_FLUSH;
      w_adv_idx   = {SOURCE_SEL_ADDRW{1'b0}};
    end else begin
      w_adv_state = ST_SELECT;
      w_adv_idx   = r_idx + SOURCE_SEL_ADDRW'(1);
    end
  end

  // The cycle that leaves SELECT is sampled too, so a one-cycle burst is never lost.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_sample     = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_start) begin
          w_next_state = ST_CLEAR;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        w_next_idx = {SOURCE_SEL_ADDRW{1'b0}};
        if (w_clr_last) begin
          w_next_state = ST_SELECT;
        end else begin
          w_next_state = ST_CLEAR;
        end
      end
      ST_SELECT: begin
        if (write_active) begin
          w_sample     = 1'b1;
          w_next_state = ST_COLLECT;
        end else if (w_to_expire) begin
          w_advance    = 1'b1;
          w_next_state = w_adv_state;
          w_next_idx   = w_adv_idx;
        end else begin
          w_next_state = ST_SELECT;
        end
      end
      ST_COLLECT: begin
        if (write_active) begin
          w_sample     = 1'b1;
          w_next_state = ST_COLLECT;
        end else begin
          w_advance    = 1'b1;
          w_next_state = w_adv_state;
          w_next_idx   = w_adv_idx;
        end
      end
      ST_FLUSH: w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_idx      <= {SOURCE_SEL_ADDRW{1'b0}};
      r_clr_addr <= {FB_ADDRW{1'b0}};
    end else begin
      r_state    <= w_next_state;
      r_idx      <= w_next_idx;
      r_clr_addr <= w_clear_en ? (r_clr_addr + FB_ADDRW'(1)) : {FB_ADDRW{1'b0}};
    end
  end

  // Status outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_awaited    <= 1'b0;
      r_frame_done <= 1'b0;
      r_buf_sel    <= 1'b0;
    end else begin
      r_busy       <= (w_next_state != ST_IDLE);
      r_awaited    <= (w_next_state == ST_SELECT) || (w_next_state == ST_COLLECT);
      r_frame_done <= (w_next_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_buf_sel <= ~r_buf_sel;
      end
    end
  end

`ifdef DRAW_MANAGER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0]        r_to_cnt;
  logic [NUM_SOURCES-1:0] r_to_flags;

  assign w_to_expire = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts idle SELECT cycles of the current source; flags are sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt   <= {TO_W{1'b0}};
      r_to_flags <= {NUM_SOURCES{1'b0}};
    end else begin
      if ((r_state == ST_SELECT) && !write_active && !w_advance) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= {TO_W{1'b0}};
      end
      if ((r_state == ST_SELECT) && w_advance) begin
        r_to_flags[r_idx] <= 1'b1;
      end
    end
  end

  assign timeout_flags = r_to_flags;
`else
  assign w_to_expire   = 1'b0;
  assign timeout_flags = {NUM_SOURCES{1'b0}};
`endif

  draw_write_stage u_write_stage (
    .clk           (clk),
    .rst           (rst),
    .i_clear_en    (w_clear_en),
    .i_clear_addr  (r_clr_addr),
    .i_clear_color (BG_COLOR),
    .i_sample_en   (w_sample),
    .i_color       (write_color_data),
    .i_transparent (write_transparent),
    .i_x           (write_x_addr),
    .i_y           (write_y_addr),
    .o_fb_we       (fb_we),
    .o_fb_addr     (fb_addr),
    .o_fb_data     (fb_data)
  );

  assign frame_done       = r_frame_done;
  assign busy             = r_busy;
  assign write_source_sel = r_idx;
  assign write_awaited    = r_awaited;
  assign fb_buffer_sel    = r_buf_sel;

endmodule

// File: tb/tb_draw_manager.sv
// Directed self-checking bench for draw_manager: clear, single pixel, filtering,
// overlap, watchdog (either build of DRAW_MANAGER_TIMEOUT_EN) and mid-frame reset.
module tb_draw_manager;
  import frame_pkg::*;

  localparam int                     NSRC = 4;
  localparam logic [COLOR_DEPTH-1:0] BG   = 9'h0A5;
  localparam int                     TO   = 16;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         frame_start;
  logic                         frame_done;
  logic                         busy;
  logic [SOURCE_SEL_ADDRW-1:0]  write_source_sel;
  logic                         write_awaited;
  logic                         write_active;
  logic [COLOR_DEPTH-1:0]       write_color_data;
  logic                         write_transparent;
  logic [DRAW_WIDTH_ADDRW-1:0]  write_x_addr;
  logic [DRAW_HEIGHT_ADDRW-1:0] write_y_addr;
  logic                         fb_we;
  logic [FB_ADDRW-1:0]          fb_addr;
  logic [COLOR_DEPTH-1:0]       fb_data;
  logic                         fb_buffer_sel;
  logic [NSRC-1:0]              timeout_flags;

  always #5 clk = ~clk;

  draw_manager #(
    .NUM_SOURCES    (NSRC),
    .BG_COLOR       (BG),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .frame_done        (frame_done),
    .busy              (busy),
    .write_source_sel  (write_source_sel),
    .write_awaited     (write_awaited),
    .write_active      (write_active),
    .write_color_data  (write_color_data),
    .write_transparent (write_transparent),
    .write_x_addr      (write_x_addr),
    .write_y_addr      (write_y_addr),
    .fb_we             (fb_we),
    .fb_addr           (fb_addr),
    .fb_data           (fb_data),
    .fb_buffer_sel     (fb_buffer_sel),
    .timeout_flags     (timeout_flags)
  );

  typedef struct {
    int src;
    int x;
    int y;
    int color;
    bit tr;
  } px_t;

  px_t         px_all[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int          drv_cyc[$];
  int          done_cnt;
  int          sel2_cnt;
  int          rst_cyc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_px(input int s, input int x, input int y, input int color, input bit tr);
    px_t p;
    p.src = s; p.x = x; p.y = y; p.color = color; p.tr = tr;
    px_all.push_back(p);
  endtask

  function automatic logic [31:0] get_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] get_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int get_cyc(input int i);
    return (i < wr_cyc.size()) ? wr_cyc[i] : -1000;
  endfunction

  // Pulses frame_start, plays the pixel table as bus sources and logs every write.
  task automatic run_frame(input int budget, input int poke_cyc, input int rst_after);
    int post;
    int idx;
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); drv_cyc.delete();
    done_cnt = 0; sel2_cnt = 0; rst_cyc = -1; post = -1;
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      frame_start = (c == poke_cyc);
      if (rst) rst = 1'b0;
      if (fb_we) begin
        wr_addr.push_back(32'(fb_addr));
        wr_data.push_back(32'(fb_data));
        wr_cyc.push_back(c);
      end
      if (frame_done) done_cnt++;
      if (write_awaited && write_source_sel == 2'd2) sel2_cnt++;
      if (rst_after > 0 && rst_cyc < 0 && drv_cyc.size() == rst_after) begin
        rst = 1'b1;
        write_active = 1'b0;
        rst_cyc = c;
        #1;
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_await", 32'(write_awaited), 32'd0);
      end else begin
        idx = -1;
        if (write_awaited) begin
          for (int i = 0; i < px_all.size(); i++) begin
            if (idx < 0 && px_all[i].src == int'(write_source_sel)) idx = i;
          end
        end
        if (idx >= 0) begin
          write_active      = 1'b1;
          write_x_addr      = DRAW_WIDTH_ADDRW'(px_all[idx].x);
          write_y_addr      = DRAW_HEIGHT_ADDRW'(px_all[idx].y);
          write_color_data  = COLOR_DEPTH'(px_all[idx].color);
          write_transparent = px_all[idx].tr;
          px_all.delete(idx);
          drv_cyc.push_back(c);
        end else begin
          write_active = 1'b0;
        end
      end
      if (post > 0) post--;
      if (done_cnt > 0 && post < 0) post = 2;
      if (post == 0) break;
    end
    frame_start  = 1'b0;
    write_active = 1'b0;
    px_all.delete();
  endtask

  initial begin
    int bad;
    logic [31:0] last170;
    rst = 1'b1; frame_start = 1'b0; write_active = 1'b0; write_color_data = '0;
    write_transparent = 1'b0; write_x_addr = '0; write_y_addr = '0;

    repeat (3) @(negedge clk);
    chk("rst_state_busy", 32'(busy), 32'd0);
    chk("rst_state_await", 32'(write_awaited), 32'd0);
    chk("rst_state_sel", 32'(write_source_sel), 32'd0);
    chk("rst_state_we", 32'(fb_we), 32'd0);
    chk("rst_state_addr", 32'(fb_addr), 32'd0);
    chk("rst_state_data", 32'(fb_data), 32'd0);
    chk("rst_state_done", 32'(frame_done), 32'd0);
    chk("rst_state_buf", 32'(fb_buffer_sel), 32'd0);
    chk("rst_state_flags", 32'(timeout_flags), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clear only: every source raises active with a transparent pixel.
    for (int s = 0; s < NSRC; s++) add_px(s, 0, 0, 0, 1'b1);
    run_frame(700, -1, 0);
    bad = 0;
    for (int i = 0; i < FB_DEPTH; i++) begin
      if (get_addr(i) !== 32'(i) || get_data(i) !== 32'(BG)) bad++;
    end
    chk("clr_seq", 32'(bad), 32'd0);
    chk("clr_cnt", 32'(wr_addr.size()), 32'd256);
    chk("clr_done", 32'(done_cnt), 32'd1);
    chk("clr_buf", 32'(fb_buffer_sel), 32'd1);
    chk("clr_idle", 32'(busy), 32'd0);

    // Single pixel (5,3) from source 0.
    add_px(0, 5, 3, 'h1FF, 1'b0);
    for (int s = 1; s < NSRC; s++) add_px(s, 0, 0, 0, 1'b1);
    run_frame(700, -1, 0);
    chk("sp_cnt", 32'(wr_addr.size()), 32'd257);
    chk("sp_addr", get_addr(256), 32'd53);
    chk("sp_data", get_data(256), 32'h1FF);
    chk("sp_lat", 32'(get_cyc(256) - ((drv_cyc.size() > 0) ? drv_cyc[0] : 0)), 32'd1);
    chk("sp_buf", 32'(fb_buffer_sel), 32'd0);

    // Off-screen and transparent pixels dropped, far corner kept; frame_start poked while busy.
    add_px(0, 16, 0, 'h1FF, 1'b0);
    add_px(0, 0, 16, 'h1FF, 1'b0);
    add_px(0, 1, 1, 'h1FF, 1'b1);
    add_px(0, 15, 15, 'h0AA, 1'b0);
    for (int s = 1; s < NSRC; s++) add_px(s, 0, 0, 0, 1'b1);
    run_frame(700, 20, 0);
    chk("flt_cnt", 32'(wr_addr.size()), 32'd257);
    chk("flt_addr", get_addr(256), 32'd255);
    chk("flt_data", get_data(256), 32'h0AA);
    chk("flt_done", 32'(done_cnt), 32'd1);
    repeat (5) @(negedge clk);
    chk("flt_noqueue", 32'(busy), 32'd0);
    chk("flt_buf", 32'(fb_buffer_sel), 32'd1);

    // Overlap at (10,10): source 1 must win.
    add_px(0, 10, 10, 'h07, 1'b0);
    add_px(0, 2, 0, 'h11, 1'b0);
    add_px(1, 10, 10, 'h38, 1'b0);
    add_px(2, 0, 0, 0, 1'b1);
    add_px(3, 0, 0, 0, 1'b1);
    run_frame(700, -1, 0);
    chk("ov_cnt", 32'(wr_addr.size()), 32'd259);
    chk("ov_first", get_data(256), 32'h07);
    chk("ov_mid_addr", get_addr(257), 32'd2);
    last170 = 32'hFFFF_FFFF;
    for (int i = FB_DEPTH; i < wr_addr.size(); i++) begin
      if (wr_addr[i] == 32'd170) last170 = wr_data[i];
    end
    chk("ov_final", last170, 32'h38);
    chk("ov_buf", 32'(fb_buffer_sel), 32'd0);

    // Source 2 never starts.
    add_px(0, 0, 0, 0, 1'b1);
    add_px(1, 0, 0, 0, 1'b1);
    add_px(3, 0, 0, 0, 1'b1);
`ifdef DRAW_MANAGER_TIMEOUT_EN
    run_frame(700, -1, 0);
    chk("to_done", 32'(done_cnt), 32'd1);
    chk("to_flags", 32'(timeout_flags), 32'b0100);
    chk("to_wait", 32'(sel2_cnt), 32'(TO));
    chk("to_cnt", 32'(wr_addr.size()), 32'd256);
    for (int s = 0; s < NSRC; s++) add_px(s, 0, 0, 0, 1'b1);
    run_frame(700, -1, 0);
    chk("to_sticky", 32'(timeout_flags), 32'b0100);
`else
    run_frame(400, -1, 0);
    chk("to_hang_done", 32'(done_cnt), 32'd0);
    chk("to_hang_busy", 32'(busy), 32'd1);
    chk("to_hang_await", 32'(write_awaited), 32'd1);
    chk("to_hang_sel", 32'(write_source_sel), 32'd2);
    chk("to_flags_off", 32'(timeout_flags), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("to_flags_clr", 32'(timeout_flags), 32'd0);

    // Reset while source 0 is mid-burst.
    for (int i = 0; i < 6; i++) add_px(0, i, 1, 'h055, 1'b0);
    run_frame(330, -1, 3);
    chk("rc_hit", 32'(rst_cyc >= 0), 32'd1);
    chk("rc_done", 32'(done_cnt), 32'd0);
    bad = 0;
    for (int i = 0; i < wr_cyc.size(); i++) begin
      if (wr_cyc[i] > rst_cyc) bad++;
    end
    chk("rc_nowrite", 32'(bad), 32'd0);
    chk("rc_idle", 32'(busy), 32'd0);
    chk("rc_buf", 32'(fb_buffer_sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
